// File: rtl/ring_ctrl_pkg.sv
// ============================================================================
// Module   : ring_ctrl_pkg
// Brief    : Shared FSM state type and default sizing for the ring sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_ctrl_pkg;

  localparam int unsigned C_DEF_WIDTH = 4;
  localparam int unsigned C_DEF_DIV_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ring_tick_gen.sv
// ============================================================================
// Module   : ring_tick_gen
// Brief    : Prescaler producing a terminal-count strobe every div_ratio+1
//            running cycles; clears on i_clear, holds when not running.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_div_ratio,
  output logic             o_tc
);

  localparam logic [DIV_W-1:0] C_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_count;
  logic             w_at_term;

  // >= rather than == so a ratio lowered below the live count ends the period now
  assign w_at_term = (r_count >= i_div_ratio);
  assign o_tc      = i_run & w_at_term;

  always_ff @(posedge mclk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (o_tc) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + C_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ring_seq_ctrl.sv
// ============================================================================
// Module   : ring_seq_ctrl
// Brief    : One-hot ring counter sequencer with IDLE/RUN/PAUSE control,
//            prescaled rotation, single-step and wrap detection.
//            Optional macro RING_REVERSE_EN enables right rotation via dir.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_seq_ctrl
  import ring_ctrl_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int DIV_W = C_DEF_DIV_W
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic [DIV_W-1:0] div_ratio,
  output logic [WIDTH-1:0] ring,
  output logic             tick,
  output logic             busy,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rst_dly;
  logic             w_start_ok;
  logic             w_step_ok;
  logic             w_restore;
  logic             w_tc;
  logic             w_rotate;
  logic             w_wrap_hit;
  logic [WIDTH-1:0] w_rot_left;
  logic [WIDTH-1:0] w_rot_val;
  logic [WIDTH-1:0] r_ring;
  logic             r_tick;
  logic             r_wrap;

  // A start coinciding with the first edge out of reset is dropped
  assign w_start_ok = start & ~r_rst_dly;

  always_ff @(posedge mclk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_rst_dly <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_dly <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_ok   = 1'b0;
    w_restore   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_start_ok) begin
          w_state_nxt = ST_RUN;
        end else if (step) begin
          w_step_ok = 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (stop) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_restore   = 1'b1;
        end else if (w_start_ok) begin
          w_state_nxt = ST_RUN;
        end else if (step) begin
          w_step_ok = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  ring_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .mclk        (mclk),
    .rst         (rst),
    .i_run       (r_state == ST_RUN),
    .i_clear     (r_state == ST_IDLE),
    .i_div_ratio (div_ratio),
    .o_tc        (w_tc)
  );

  assign w_rotate   = w_tc | w_step_ok;
  assign w_rot_left = {r_ring[WIDTH-2:0], r_ring[WIDTH-1]};

`ifdef RING_REVERSE_EN
  logic [WIDTH-1:0] w_rot_right;
  assign w_rot_right = {r_ring[0], r_ring[WIDTH-1:1]};
  assign w_rot_val   = dir ? w_rot_right : w_rot_left;
  assign w_wrap_hit  = dir ? (r_ring == C_LSB_ONLY) : (r_ring == C_MSB_ONLY);
`else
  logic w_unused_dir;
  assign w_unused_dir = dir;
  assign w_rot_val    = w_rot_left;
  assign w_wrap_hit   = (r_ring == C_MSB_ONLY);
`endif

  always_ff @(posedge mclk) begin
    if (!rst) begin
      r_ring <= C_LSB_ONLY;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_tc;
      r_wrap <= w_rotate & w_wrap_hit;
      if (w_restore) begin
        r_ring <= C_LSB_ONLY;
      end else if (w_rotate) begin
        r_ring <= w_rot_val;
      end
    end
  end

  assign ring = r_ring;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_ring_seq_ctrl.sv
// ============================================================================
// Module   : tb_ring_seq_ctrl
// Brief    : Scoreboard bench for ring_seq_ctrl; honours RING_REVERSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_seq_ctrl;

  logic       mclk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] div_ratio = 8'd0;
  logic [3:0] ring;
  logic       tick;
  logic       busy;
  logic       wrap;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         ecyc;
    logic [3:0] ring;
    logic       tick;
    logic       wrap;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;

  ring_seq_ctrl #(
    .WIDTH (4),
    .DIV_W (8)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .dir       (dir),
    .div_ratio (div_ratio),
    .ring      (ring),
    .tick      (tick),
    .busy      (busy),
    .wrap      (wrap)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  // Consumer side: every tick/wrap event must match the next expected entry
  always @(negedge mclk) begin
    if (rst && (tick || wrap)) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: cyc=%0d ring=%b tick=%b wrap=%b, none expected",
                 cyc, ring, tick, wrap);
      end else begin
        m_e = sbq.pop_front();
        if (cyc !== m_e.ecyc || ring !== m_e.ring || tick !== m_e.tick || wrap !== m_e.wrap) begin
          n_err++;
          $display("FAIL event: got cyc=%0d ring=%b tick=%b wrap=%b, expected cyc=%0d ring=%b tick=%b wrap=%b",
                   cyc, ring, tick, wrap, m_e.ecyc, m_e.ring, m_e.tick, m_e.wrap);
        end
      end
    end
  end

  task automatic clk1();
    @(posedge mclk);
    #1;
  endtask

  task automatic push_evt(input int c, input logic [3:0] r, input logic t, input logic w);
    exp_t e;
    e.ecyc = c;
    e.ring = r;
    e.tick = t;
    e.wrap = w;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) clk1();
    rst = 1'b1;
    repeat (5) clk1();
    n_cmp++; if (ring !== 4'b0001) begin n_err++; $display("FAIL reset_ring: got %b expected 0001", ring); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
  endtask

  task automatic test_run();
    int e0;
    div_ratio = 8'd3;
    dir = 1'b0;
    start = 1'b1; clk1(); start = 1'b0;
    e0 = cyc;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy: got %b expected 1", busy); end
    push_evt(e0 + 4,  4'b0010, 1'b1, 1'b0);
    push_evt(e0 + 8,  4'b0100, 1'b1, 1'b0);
    push_evt(e0 + 12, 4'b1000, 1'b1, 1'b0);
    push_evt(e0 + 16, 4'b0001, 1'b1, 1'b1);
    repeat (16) clk1();
    stop = 1'b1; clk1(); stop = 1'b0;
    n_cmp++; if (sbq.size() !== 0) begin n_err++; $display("FAIL run_pending: got %0d left expected 0", sbq.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_pause_busy: got %b expected 0", busy); end
    stop = 1'b1; clk1(); stop = 1'b0;
    n_cmp++; if (ring !== 4'b0001) begin n_err++; $display("FAIL run_idle_ring: got %b expected 0001", ring); end
  endtask

  task automatic test_pause();
    int r0;
    div_ratio = 8'd2;
    start = 1'b1; clk1(); start = 1'b0;
    stop = 1'b1; clk1(); stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pause_busy[%0d]: got %b expected 0", i, busy); end
      clk1();
    end
    start = 1'b1; clk1(); start = 1'b0;
    r0 = cyc;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL resume_busy: got %b expected 1", busy); end
    push_evt(r0 + 2, 4'b0010, 1'b1, 1'b0);
    push_evt(r0 + 5, 4'b0100, 1'b1, 1'b0);
    repeat (5) clk1();
    stop = 1'b1; clk1(); stop = 1'b0;
    n_cmp++; if (sbq.size() !== 0) begin n_err++; $display("FAIL resume_pending: got %0d left expected 0", sbq.size()); end
    n_cmp++; if (ring !== 4'b0100) begin n_err++; $display("FAIL pause_ring: got %b expected 0100", ring); end
    stop = 1'b1; start = 1'b1; clk1(); stop = 1'b0; start = 1'b0;
    n_cmp++; if (ring !== 4'b0001) begin n_err++; $display("FAIL stop_start_ring: got %b expected 0001", ring); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_start_busy: got %b expected 0", busy); end
    step = 1'b1; clk1(); step = 1'b0;
    n_cmp++; if (ring !== 4'b0010) begin n_err++; $display("FAIL idle_step1: got %b expected 0010", ring); end
    step = 1'b1; clk1(); step = 1'b0;
    n_cmp++; if (ring !== 4'b0100) begin n_err++; $display("FAIL idle_step2: got %b expected 0100", ring); end
    n_cmp++; if (tick !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_step_flags: got tick=%b busy=%b expected 0 0", tick, busy); end
  endtask

  task automatic test_step();
    step = 1'b1; clk1(); step = 1'b0;
    n_cmp++; if (ring !== 4'b1000) begin n_err++; $display("FAIL step3: got %b expected 1000", ring); end
    push_evt(cyc + 1, 4'b0001, 1'b0, 1'b1);
    step = 1'b1; clk1(); step = 1'b0;
    n_cmp++; if (ring !== 4'b0001) begin n_err++; $display("FAIL step_wrap_ring: got %b expected 0001", ring); end
    clk1();
    n_cmp++; if (sbq.size() !== 0) begin n_err++; $display("FAIL step_wrap_pending: got %0d left expected 0", sbq.size()); end
    div_ratio = 8'd200;
    start = 1'b1; clk1(); start = 1'b0;
    step = 1'b1; clk1(); step = 1'b0;
    n_cmp++; if (ring !== 4'b0001 || busy !== 1'b1) begin n_err++; $display("FAIL run_step_ignored: got ring=%b busy=%b expected 0001 1", ring, busy); end
    stop = 1'b1; clk1(); stop = 1'b0;
    step = 1'b1; clk1(); step = 1'b0;
    n_cmp++; if (ring !== 4'b0010 || busy !== 1'b0) begin n_err++; $display("FAIL pause_step: got ring=%b busy=%b expected 0010 0", ring, busy); end
    stop = 1'b1; clk1(); stop = 1'b0;
    n_cmp++; if (ring !== 4'b0001) begin n_err++; $display("FAIL restore_ring: got %b expected 0001", ring); end
  endtask

  task automatic test_div0_dir();
    int e0;
    div_ratio = 8'd0;
    dir = 1'b1;
    start = 1'b1; clk1(); start = 1'b0;
    e0 = cyc;
`ifdef RING_REVERSE_EN
    push_evt(e0 + 1, 4'b1000, 1'b1, 1'b1);
    push_evt(e0 + 2, 4'b0100, 1'b1, 1'b0);
    push_evt(e0 + 3, 4'b0010, 1'b1, 1'b0);
    push_evt(e0 + 4, 4'b0001, 1'b1, 1'b0);
`else
    push_evt(e0 + 1, 4'b0010, 1'b1, 1'b0);
    push_evt(e0 + 2, 4'b0100, 1'b1, 1'b0);
    push_evt(e0 + 3, 4'b1000, 1'b1, 1'b0);
    push_evt(e0 + 4, 4'b0001, 1'b1, 1'b1);
`endif
    repeat (4) clk1();
    div_ratio = 8'd200;
    stop = 1'b1; clk1(); stop = 1'b0;
    clk1();
    stop = 1'b1; clk1(); stop = 1'b0;
    dir = 1'b0;
    n_cmp++; if (sbq.size() !== 0) begin n_err++; $display("FAIL dir_pending: got %0d left expected 0", sbq.size()); end
    n_cmp++; if (ring !== 4'b0001 || busy !== 1'b0) begin n_err++; $display("FAIL dir_idle: got ring=%b busy=%b expected 0001 0", ring, busy); end
  endtask

  task automatic test_div_change();
    int e0;
    div_ratio = 8'd9;
    dir = 1'b0;
    start = 1'b1; clk1(); start = 1'b0;
    e0 = cyc;
    repeat (6) clk1();
    div_ratio = 8'd4;
    push_evt(e0 + 7,  4'b0010, 1'b1, 1'b0);
    push_evt(e0 + 12, 4'b0100, 1'b1, 1'b0);
    push_evt(e0 + 17, 4'b1000, 1'b1, 1'b0);
    push_evt(e0 + 22, 4'b0001, 1'b1, 1'b1);
    repeat (16) clk1();
    stop = 1'b1; clk1(); stop = 1'b0;
    n_cmp++; if (sbq.size() !== 0) begin n_err++; $display("FAIL divchg_pending: got %0d left expected 0", sbq.size()); end
    stop = 1'b1; clk1(); stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL divchg_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int e0;
    div_ratio = 8'd1;
    start = 1'b1; clk1(); start = 1'b0;
    e0 = cyc;
    push_evt(e0 + 2, 4'b0010, 1'b1, 1'b0);
    repeat (3) clk1();
    rst = 1'b0; clk1();
    n_cmp++; if (ring !== 4'b0001 || tick !== 1'b0 || wrap !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: got ring=%b tick=%b wrap=%b busy=%b expected 0001 0 0 0", ring, tick, wrap, busy);
    end
    rst = 1'b1; start = 1'b1; clk1(); start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_start: got busy=%b expected 0", busy); end
    repeat (4) clk1();
    n_cmp++; if (busy !== 1'b0 || ring !== 4'b0001) begin n_err++; $display("FAIL post_release: got busy=%b ring=%b expected 0 0001", busy, ring); end
    n_cmp++; if (sbq.size() !== 0) begin n_err++; $display("FAIL midrun_pending: got %0d left expected 0", sbq.size()); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_step();
    test_div0_dir();
    test_div_change();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ring_seq_ctrl.md
RING_SEQ_CTRL -- requirements
Module: ring_seq_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, ring counter width (min 2).
REQ-002 SHALL provide parameter DIV_W, default 8, divide-ratio width.
REQ-003 SHALL provide port mclk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port start  input  1  run/resume request, one-cycle pulse.
REQ-006 SHALL provide port stop  input  1  pause/halt request, one-cycle pulse.
REQ-007 SHALL provide port step  input  1  single-rotate request, one-cycle pulse.
REQ-008 SHALL provide port dir  input  1  rotate direction: 0 = left, 1 = right.
REQ-009 SHALL provide port div_ratio  input  DIV_W  prescaler terminal count; a rotation occurs every div_ratio+1 cycles.
REQ-010 SHALL provide port ring  output  WIDTH  one-hot ring counter value.
REQ-011 SHALL provide port tick  output  1  registered one-cycle pulse marking each RUN rotation.
REQ-012 SHALL provide port busy  output  1  high while in RUN.
REQ-013 SHALL provide port wrap  output  1  registered one-cycle pulse when the ring completes a full revolution.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and PAUSE.
REQ-015 Transitions SHALL be: IDLE-start->RUN; RUN-stop->PAUSE; PAUSE-start->RUN; PAUSE-stop->IDLE; all others hold.
REQ-016 Simultaneous requests SHALL be prioritised stop > start > step.
REQ-017 Prescaler count SHALL clear to 0 in IDLE, hold in PAUSE, and increment by 1 per cycle in RUN.
REQ-018 In RUN, on the edge where count >= div_ratio, SHALL clear count to 0, rotate ring, and assert tick in the following cycle, so tick and the new ring value are visible together.
REQ-019 div_ratio = 0 SHALL rotate every cycle; div_ratio changed mid-count below current count SHALL terminate the period on the next edge (>= compare).
REQ-020 First rotation after start SHALL occur div_ratio+1 cycles after the start edge when resumed from IDLE; resume from PAUSE continues from the held count.
REQ-021 Left rotate SHALL move bit i to bit i+1, with the MSB to the LSB; right rotate SHALL be the inverse.
REQ-022 step in IDLE or PAUSE SHALL rotate ring once on the next edge without tick, leaving state and count unchanged; step in RUN SHALL be ignored.
REQ-023 wrap SHALL pulse when the ring becomes LSB-only from MSB-only (left), or MSB-only from LSB-only (right), whether by tick or step.
REQ-024 PAUSE-stop->IDLE SHALL restore ring to 1 (LSB only).
REQ-025 busy SHALL be combinational from state (state == RUN); tick and wrap SHALL never assert outside a rotation.

Reset
REQ-026 While rst = 0 at a rising mclk edge: state = IDLE, count = 0, ring = 1, tick = 0, wrap = 0, busy = 0.
REQ-027 Reset mid-RUN SHALL discard any pending rotation; a start on the reset-release edge SHALL be ignored.

Configuration
REQ-028 Macro RING_REVERSE_EN: when defined, dir SHALL select direction per REQ-021; when undefined, dir SHALL be ignored, rotation SHALL always be left, and no right-rotate logic SHALL be synthesised.

Structure
REQ-029 Shared package ring_ctrl_pkg SHALL hold the FSM state typedef and default WIDTH/DIV_W constants.
REQ-030 The prescaler SHALL be a sub-module ring_tick_gen (inputs: run/clear/div_ratio; output: terminal-count strobe).

Verification
REQ-031 Reset, then idle 5 cycles -> ring = 4'b0001, tick = 0, busy = 0, wrap = 0.
REQ-032 div_ratio = 3, start -> tick every 4 cycles; ring sequence 0010, 0100, 1000, 0001; wrap on 0001.
REQ-033 div_ratio = 2, start, stop after 1 cycle, wait 10, start -> next tick 2 cycles after resume; busy low throughout pause.
REQ-034 In PAUSE with stop and start on the same cycle -> IDLE, ring = 0001; step in IDLE twice -> 0100, no tick.
REQ-035 With RING_REVERSE_EN, dir = 1, div_ratio = 0 -> ring 1000, 0100, 0010, 0001, one per cycle; wrap on 1000. Without the macro, the same stimulus rotates left.
REQ-036 div_ratio = 9, start, and at count 6 write div_ratio = 4 -> rotation on the next edge, then every 5 cycles.
